// File: rtl/pulse_launch_pkg.sv
// Shared types and limits for the pulse launch scheduler and its picker.
package pulse_launch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned GAP_MIN = 2;
    localparam int unsigned N_MIN   = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping mod N.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    logic [ID_W-1:0] pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = ID_W'((32'(last) + k) % N);
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/pulse_launch_arb.sv
// Round-robin scheduler feeding one shared fast-to-slow pulse synchronizer,
// spacing launch pulses at least GAP fast cycles apart.
module pulse_launch_arb
    import pulse_launch_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned GAP   = 20,
    parameter int unsigned ID_W  = $clog2(N),
    parameter int unsigned CNT_W = $clog2(GAP)
) (
    input  logic            clk_fast,
    input  logic            rst,
    input  logic            enable,
    input  logic [N-1:0]    req_pulse,
    output logic [N-1:0]    pend,
    output logic [N-1:0]    drop,
    output logic            pulse_out,
    output logic [ID_W-1:0] pulse_id,
    output logic            busy
);

    if (N < N_MIN) begin : g_n_check
        $error("pulse_launch_arb: N must be at least %0d", N_MIN);
    end
    if (GAP < GAP_MIN) begin : g_gap_check
        $error("pulse_launch_arb: GAP must be at least %0d", GAP_MIN);
    end

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0] last;
    logic            pick_valid;
    logic [ID_W-1:0] pick_idx;
    logic            grant_c;
    logic [N-1:0]    grant_mask_c;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req   (pend),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Final HOLD cycle (cnt==0) may relaunch directly, keeping launches exactly GAP apart.
    always_comb begin
        grant_c      = enable && pick_valid && ((state == IDLE) || (cnt == '0));
        grant_mask_c = grant_c ? (N'(1) << pick_idx) : '0;
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= ID_W'(N - 1);
            pend      <= '0;
            drop      <= '0;
            pulse_out <= 1'b0;
            pulse_id  <= '0;
            busy      <= 1'b0;
        end else begin
            // A re-request on the winner's grant edge keeps it pending without a drop.
            pend      <= (pend & ~grant_mask_c) | req_pulse;
            drop      <= req_pulse & pend & ~grant_mask_c;
            pulse_out <= grant_c;
            if (grant_c) begin
                pulse_id <= pick_idx;
                last     <= pick_idx;
                cnt      <= CNT_W'(GAP - 1);
                state    <= HOLD;
                busy     <= 1'b1;
            end else if (state == HOLD) begin
                if (cnt == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule
